// File: rtl/lb_pkg.sv
// Shared defaults, state encoding and helpers for the line-buffer fill controller.
package lb_pkg;

    localparam int unsigned DEF_PIX_W  = 8;
    localparam int unsigned DEF_LINE_W = 800;
    localparam int unsigned DEF_ADDR_W = 10;

    // Width of one 3-pixel read slice at the default pixel width.
    localparam int unsigned SLICE_W = 3 * DEF_PIX_W;

    // Controller states.
    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_READY  = 2'd1;
    localparam logic [1:0] ST_REFILL = 2'd2;

    // Advance a buffer index 0 -> 1 -> 2 -> 0.
    function automatic logic [1:0] next_sel(input logic [1:0] sel);
        return (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    endfunction

endpackage

// File: rtl/lb_line_ram.sv
// One physical line buffer: single write port, registered 3-pixel read with
// zero padding for columns beyond the end of the line.
module lb_line_ram #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned LINE_W = 800,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [PIX_W-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [3*PIX_W-1:0]   rd_data
);

    localparam int unsigned IDX_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    // Two extra bits so rd_addr+2 never wraps back into the line.
    localparam int unsigned COL_W = ADDR_W + 2;

    logic [PIX_W-1:0] mem [LINE_W];
    logic [COL_W-1:0] col [3];
    logic [PIX_W-1:0] pix [3];

    // Pixel storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[IDX_W'(wr_addr)] <= wr_data;
        end
    end

    // Fetch three consecutive columns, zero past the right edge.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            pix[k] = '0;
            col[k] = COL_W'(rd_addr) + COL_W'(k);
            if (col[k] < COL_W'(LINE_W)) begin
                pix[k] = mem[IDX_W'(col[k])];
            end
        end
    end

    // Registered read slice, held while rd_en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= {pix[2], pix[1], pix[0]};
        end
    end

endmodule

// File: rtl/lb_fill_ctrl.sv
// Fills three rotating line buffers from a raster stream and serves 3-row
// window reads once three complete rows are held.
module lb_fill_ctrl
    import lb_pkg::*;
#(
    parameter int unsigned PIX_W  = DEF_PIX_W,
    parameter int unsigned LINE_W = DEF_LINE_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIX_W-1:0]     pix_in,
    input  logic                 pix_valid,
    output logic                 pix_ready,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic                 row_done,
    output logic [3*PIX_W-1:0]   LB1,
    output logic [3*PIX_W-1:0]   LB2,
    output logic [3*PIX_W-1:0]   LB3,
    output logic                 data_valid,
    output logic [1:0]           oldest
);

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [1:0]        wr_sel;
    logic [1:0]        wr_sel_d;
    logic [ADDR_W-1:0] wr_col;
    logic [ADDR_W-1:0] wr_col_d;
    logic [1:0]        rows_held;
    logic [1:0]        rows_held_d;
    logic [1:0]        oldest_d;
    logic              accept;
    logic              last_col;
    logic [3*PIX_W-1:0] slice [3];

    // pix_ready is only high outside READY, so accepts never collide with reads.
    assign accept   = pix_valid && pix_ready;
    assign last_col = (wr_col == ADDR_W'(LINE_W - 1));

    // Next-state and write-pointer logic.
    always_comb begin
        state_d     = state;
        wr_sel_d    = wr_sel;
        wr_col_d    = wr_col;
        rows_held_d = rows_held;
        oldest_d    = oldest;
        case (state)
            ST_FILL: begin
                if (accept) begin
                    if (last_col) begin
                        wr_col_d    = '0;
                        wr_sel_d    = next_sel(wr_sel);
                        rows_held_d = rows_held + 2'd1;
                        if (rows_held == 2'd2) begin
                            state_d  = ST_READY;
                            oldest_d = 2'd0;
                        end
                    end else begin
                        wr_col_d = wr_col + ADDR_W'(1);
                    end
                end
            end
            ST_READY: begin
                if (row_done) begin
                    state_d = ST_REFILL;
                end
            end
            ST_REFILL: begin
                if (accept) begin
                    if (last_col) begin
                        wr_col_d = '0;
                        wr_sel_d = next_sel(wr_sel);
                        oldest_d = next_sel(oldest);
                        state_d  = ST_READY;
                    end else begin
                        wr_col_d = wr_col + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State, pointers and registered handshake/valid outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_FILL;
            wr_sel     <= 2'd0;
            wr_col     <= '0;
            rows_held  <= 2'd0;
            oldest     <= 2'd0;
            pix_ready  <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_d;
            wr_sel     <= wr_sel_d;
            wr_col     <= wr_col_d;
            rows_held  <= rows_held_d;
            oldest     <= oldest_d;
            pix_ready  <= (state_d != ST_READY);
            data_valid <= (state == ST_READY) && (state_d == ST_READY);
        end
    end

    // Three physical line buffers, written in rotation, read in parallel.
    for (genvar i = 0; i < 3; i++) begin : g_ram
        lb_line_ram #(
            .PIX_W  (PIX_W),
            .LINE_W (LINE_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (accept && (wr_sel == 2'(i))),
            .wr_addr (wr_col),
            .wr_data (pix_in),
            .rd_en   (rd_en),
            .rd_addr (rd_addr),
            .rd_data (slice[i])
        );
    end

    assign LB1 = slice[0];
    assign LB2 = slice[1];
    assign LB3 = slice[2];

endmodule

// File: tb/tb_lb_fill_ctrl.sv
// Self-checking bench for lb_fill_ctrl with an 8-pixel line.
module tb_lb_fill_ctrl;
    import lb_pkg::*;

    localparam int unsigned PW = 8;
    localparam int unsigned LW = 8;
    localparam int unsigned AW = DEF_ADDR_W;

    typedef struct packed {
        logic [SLICE_W-1:0] lb3;
        logic [SLICE_W-1:0] lb2;
        logic [SLICE_W-1:0] lb1;
    } rd_exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [PW-1:0]      pix_in;
    logic               pix_valid;
    logic               pix_ready;
    logic               rd_en;
    logic [AW-1:0]      rd_addr;
    logic               row_done;
    logic [SLICE_W-1:0] lb1;
    logic [SLICE_W-1:0] lb2;
    logic [SLICE_W-1:0] lb3;
    logic               data_valid;
    logic [1:0]         oldest;

    int checks = 0;
    int errors = 0;

    logic [PW-1:0] mdl [3][LW];
    rd_exp_t       sb_q[$];

    lb_fill_ctrl #(.PIX_W(PW), .LINE_W(LW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .row_done   (row_done),
        .LB1        (lb1),
        .LB2        (lb2),
        .LB3        (lb3),
        .data_valid (data_valid),
        .oldest     (oldest)
    );

    always #5 clk = ~clk;

    function automatic logic [SLICE_W-1:0] model_slice(input int b, input int addr);
        logic [SLICE_W-1:0] s;
        s = '0;
        for (int k = 0; k < 3; k++) begin
            if (addr + k < LW) s[k*PW +: PW] = mdl[b][addr+k];
        end
        return s;
    endfunction

    // Drive n pixels into buffer b starting at column 0; in refill mode also
    // require pix_ready high and data_valid low on every pixel.
    task automatic stream_row(input int b, input int first, input int n, input bit refill);
        bit done;
        bit rdy;
        for (int c = 0; c < n; c++) begin
            pix_valid = 1'b1;
            pix_in    = PW'(first + c);
            done      = 1'b0;
            for (int w = 0; w < 20 && !done; w++) begin
                rdy = pix_ready;
                if (refill) begin
                    checks++;
                    if (pix_ready !== 1'b1 || data_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL refill_hs col=%0d: pix_ready=%b data_valid=%b, required 1/0", c, pix_ready, data_valid);
                    end
                end
                @(posedge clk); #1;
                if (rdy) begin
                    done = 1'b1;
                    mdl[b][c] = PW'(first + c);
                end
            end
            if (!done) begin
                errors++;
                $display("FAIL accept_timeout buf=%0d col=%0d: pixel not accepted within 20 cycles", b, c);
            end
        end
        pix_valid = 1'b0;
    endtask

    // Issue one read, push the model's expectation, pop and compare next cycle.
    task automatic do_read(input int addr, input logic dv_exp, input bit with_done);
        rd_exp_t e;
        rd_exp_t got;
        rd_en    = 1'b1;
        rd_addr  = AW'(addr);
        row_done = with_done;
        e.lb1 = model_slice(0, addr);
        e.lb2 = model_slice(1, addr);
        e.lb3 = model_slice(2, addr);
        sb_q.push_back(e);
        @(posedge clk); #1;
        rd_en    = 1'b0;
        row_done = 1'b0;
        e   = sb_q.pop_front();
        got = {lb3, lb2, lb1};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL read_data addr=%0d: got %h/%h/%h, required %h/%h/%h", addr, lb1, lb2, lb3, e.lb1, e.lb2, e.lb3);
        end
        checks++;
        if (data_valid !== dv_exp) begin
            errors++;
            $display("FAIL read_valid addr=%0d: data_valid=%b, required %b", addr, data_valid, dv_exp);
        end
    endtask

    task automatic check_ready_state(input string tag, input logic [1:0] old_exp);
        checks++;
        if (pix_ready !== 1'b0 || data_valid !== 1'b0 || oldest !== old_exp) begin
            errors++;
            $display("FAIL %s_entry: pix_ready=%b data_valid=%b oldest=%0d, required 0/0/%0d", tag, pix_ready, data_valid, oldest, old_exp);
        end
        @(posedge clk); #1;
        checks++;
        if (data_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: data_valid=%b, required 1", tag, data_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b0; pix_in = '0; rd_en = 1'b0; rd_addr = '0; row_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (pix_ready !== 1'b0 || data_valid !== 1'b0 || oldest !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctrl: pix_ready=%b data_valid=%b oldest=%0d, required 0/0/0", pix_ready, data_valid, oldest);
        end
        checks++;
        if (lb1 !== '0 || lb2 !== '0 || lb3 !== '0) begin
            errors++;
            $display("FAIL reset_lb: %h/%h/%h, required 0/0/0", lb1, lb2, lb3);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill(input int base);
        for (int r = 0; r < 3; r++) stream_row(r, base + r * LW, LW, 1'b0);
        check_ready_state("fill", 2'd0);
    endtask

    task automatic test_read();
        do_read(2, 1'b1, 1'b0);
        checks++;
        if (lb1 !== 24'h050403 || lb2 !== 24'h0D0C0B || lb3 !== 24'h151413) begin
            errors++;
            $display("FAIL read_addr2_const: %h/%h/%h, required 050403/0D0C0B/151413", lb1, lb2, lb3);
        end
        do_read(6, 1'b1, 1'b0);
        checks++;
        if (lb1 !== 24'h000807 || lb2 !== 24'h00100F || lb3 !== 24'h001817) begin
            errors++;
            $display("FAIL read_pad_const: %h/%h/%h, required 000807/00100F/001817", lb1, lb2, lb3);
        end
        do_read(7, 1'b1, 1'b0);
        // Held value with rd_en low.
        @(posedge clk); #1;
        checks++;
        if (lb1 !== {16'h0000, mdl[0][7]}) begin
            errors++;
            $display("FAIL read_hold: LB1=%h, required %h", lb1, {16'h0000, mdl[0][7]});
        end
    endtask

    task automatic test_refill();
        row_done = 1'b1;
        @(posedge clk); #1;
        row_done = 1'b0;
        stream_row(0, 25, LW, 1'b1);
        check_ready_state("refill", 2'd1);
        do_read(0, 1'b1, 1'b0);
        checks++;
        if (lb1 !== 24'h1B1A19) begin
            errors++;
            $display("FAIL refill_read: LB1=%h, required 1B1A19", lb1);
        end
    endtask

    task automatic test_stall();
        pix_valid = 1'b1;
        pix_in    = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (pix_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_ready cyc=%0d: pix_ready=%b, required 0", i, pix_ready);
            end
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        do_read(0, 1'b1, 1'b0);
        do_read(5, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        // Read and release together: old contents served, valid drops.
        do_read(1, 1'b0, 1'b1);
        stream_row(1, 33, LW, 1'b1);
        check_ready_state("b2b", 2'd2);
        do_read(3, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        row_done = 1'b1;
        @(posedge clk); #1;
        row_done = 1'b0;
        // Fresh fill after a mid-stream reset.
        rst = 1'b1;
        #1;
        checks++;
        if (data_valid !== 1'b0 || oldest !== 2'd0 || pix_ready !== 1'b0 || lb1 !== '0) begin
            errors++;
            $display("FAIL midrst_state: data_valid=%b oldest=%0d pix_ready=%b LB1=%h, required 0/0/0/0", data_valid, oldest, pix_ready, lb1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        stream_row(0, 8'h61, 12 - LW, 1'b0);
        stream_row(0, 100, LW, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (data_valid !== 1'b0 || oldest !== 2'd0 || pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL midfill_rst: data_valid=%b oldest=%0d pix_ready=%b, required 0/0/0", data_valid, oldest, pix_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        test_fill(8'h41);
        do_read(1, 1'b1, 1'b0);
        do_read(6, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_fill(1);
        test_read();
        test_refill();
        test_stall();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/lb_fill_ctrl.md
Name: lb_fill_ctrl

Overview:
- Producer/responder side of the 3-row line-buffer read interface used by the convolution MAC controller.
- Accepts a raster pixel stream and writes it into three physical line buffers in rotation.
- Once three complete rows are held, asserts the window-available condition and serves the consumer's rd_en/rd_addr reads with three 24-bit row slices, LB1, LB2 and LB3.
- Stalls the stream until the consumer releases the oldest row, then refills that buffer.

Parameters:
- PIX_W, 8, bits per pixel. Each LBx output carries 3 pixels, so it is 3*PIX_W bits wide.
- LINE_W, 800, pixels per row. Range is 4..1024.
- ADDR_W, 10, width of rd_addr. Must satisfy 2**ADDR_W >= LINE_W.

Ports:
- clk  in  1  Rising-edge clock. This is the only clock.
- rst  in  1  Asynchronous, active-high reset.
- pix_in  in  PIX_W  Stream pixel, in raster order.
- pix_valid  in  1  pix_in is valid this cycle.
- pix_ready  out  1  The block can accept a pixel. A pixel transfers when pix_valid && pix_ready.
- rd_en  in  1  Read request from the consumer.
- rd_addr  in  ADDR_W  Column of the first of 3 consecutive pixels to read.
- row_done  in  1  Single-cycle pulse from the consumer: the oldest row is finished and may be overwritten.
- LB1  out  3*PIX_W  Read slice from physical buffer 0.
- LB2  out  3*PIX_W  Read slice from physical buffer 1.
- LB3  out  3*PIX_W  Read slice from physical buffer 2.
- data_valid  out  1  A window is available and LB1..LB3 hold the response to the previous cycle's read.
- oldest  out  2  Index (0..2) of the physical buffer holding the top (oldest) row of the current window.

Behaviour:
Reset values (asynchronous, on rst):
- State is FILL; wr_sel=0; wr_col=0; rows_held=0.
- pix_ready=0 during reset.
- LB1=LB2=LB3=0; data_valid=0; oldest=0.

States:
- FILL: initial fill of rows 0..2.
  - pix_ready=1.
  - Each accepted pixel is written to buffer wr_sel at column wr_col, then wr_col increments.
  - When wr_col reaches LINE_W-1 on an accept: wr_col goes to 0, wr_sel advances 0→1→2→0, and rows_held increments.
  - When rows_held reaches 3 the state goes to READY; at that point oldest=0.
- READY: window valid.
  - pix_ready=0.
  - Reads are served (see below).
  - row_done → REFILL. The buffer being refilled is the current oldest, which is also the current wr_sel.
- REFILL:
  - pix_ready=1; data_valid forced to 0.
  - Writes go to buffer wr_sel using the same column and wrap rules as FILL.
  - On completion of the row: oldest advances modulo 3, wr_sel advances modulo 3, state → READY.

Reads:
- Memory read is registered, with 1-cycle latency.
- On a cycle where rd_en=1, each LBx is updated from its buffer:
  - LBx[PIX_W-1:0] = pixel at rd_addr
  - next PIX_W bits = pixel at rd_addr+1
  - top PIX_W bits = pixel at rd_addr+2
- Any column >= LINE_W reads as 0 (zero padding at the right edge; no wrap).
- When rd_en=0, LBx hold their values.
- data_valid is registered: data_valid <= (state==READY) && (next state==READY).
  - The consumer may therefore latch LBx in any cycle where data_valid=1, provided rd_en was high in the prior cycle.

Boundary and corner cases:
- rd_en while not READY: LBx still update, but data_valid stays 0.
- row_done outside READY is ignored. row_done together with rd_en in READY: the read is served from the pre-refill contents, and data_valid=0 from the next cycle.
- pix_valid while pix_ready=0: the pixel is not consumed, and the source must hold it.
- Write and read of the same buffer/column in one cycle: this cannot occur, because writes happen only when not READY.
- rst asserted mid-row: all state is discarded, buffer contents are don't-care, and FILL restarts at row 0.

Decomposition:
- Shared package lb_pkg holds: PIX_W, LINE_W, ADDR_W defaults; the state encoding {FILL, READY, REFILL} as a 2-bit localparam set; and the slice width SLICE_W=3*PIX_W.
- One sub-module, lb_line_ram, instantiated 3 times:
  - LINE_W x PIX_W storage.
  - 1 write port.
  - Registered 3-pixel read with zero padding beyond LINE_W.

Test Plan (LINE_W=8, PIX_W=8):
- Reset then stream pixels 1..24 with pix_valid held high.
  - Expect pix_ready to drop after pixel 24, state READY, oldest=0, and data_valid=1 one cycle later.
- In READY, pulse rd_en with rd_addr=2.
  - Next cycle: LB1=0x050403, LB2=0x0D0C0B, LB3=0x151413, data_valid=1.
- rd_en with rd_addr=6.
  - Expect LB1=0x000807, LB2=0x00100F, LB3=0x001817 (zero padding).
- Pulse row_done, then stream 25..32.
  - During the refill: data_valid=0 and pix_ready=1.
  - Afterwards: oldest=1, and a read at rd_addr=0 gives LB1=0x1B1A19.
- Hold pix_valid=1 in READY for 5 cycles.
  - Expect no writes and pix_ready=0; buffer contents unchanged on re-read.
- Assert rst after pixel 12 of the initial fill.
  - Expect data_valid=0 and oldest=0; refilling 24 fresh pixels reaches READY normally.
